// File: rtl/sdelay_pkg.sv
// Purpose: shared types and constants for the sdelay delay-model demonstrator.
// Latency: n/a (declarations only).
// Backpressure: none, the block has no handshake.
package sdelay_pkg;

  // Blind tracker FSM states
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } trk_state_t;

  localparam int DEFAULT_DELAY = 2;
  localparam int MAX_DELAY     = 15;
  // Wide enough to hold DELAY-1 for any legal DELAY
  localparam int CNT_W         = $clog2(MAX_DELAY + 1);

endpackage

// File: rtl/sdelay_blind_tracker.sv
// Purpose: blind delay tracker; arms on an event and ignores further events until expiry.
// Latency: output updates DELAY edges after the triggering event.
// Backpressure: none, events seen while armed are dropped.
module sdelay_blind_tracker
  import sdelay_pkg::*;
#(
  parameter int DELAY           = DEFAULT_DELAY,
  parameter bit SAMPLE_AT_EVENT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic evt,
  output logic y
);

  trk_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cap_q, cap_d;
  logic             y_q, y_d;

  // Next-state: arm on event in IDLE, count down in WAIT, drive y at expiry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (evt) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(DELAY - 1);
          cap_d   = a;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Expiry edge is blind: an event here is not seen by IDLE
          state_d = IDLE;
          y_d     = SAMPLE_AT_EVENT ? cap_q : a;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset drops any pending update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= 1'b0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      y_q     <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/sdelay.sv
// Purpose: shows transport, inertial, blind and queued delay models side by side on one input.
// Latency: DELAY edges for every model; all outputs registered.
// Backpressure: none, purely synchronous.
module sdelay
  import sdelay_pkg::*;
#(
  parameter int DELAY = DEFAULT_DELAY
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  output logic yblhs,
  output logic ybrhs,
  output logic ynblhs,
  output logic ynbrhs,
  output logic ycbl
);

  logic             a_prev_q;
  logic             evt;
  // hist_q[i] holds a from i+1 edges ago; flag_q[i] likewise holds the event flag
  logic [DELAY-1:0] hist_q, hist_d;
  logic [DELAY-1:0] flag_q, flag_d;
  logic             ynbrhs_q, ynbrhs_d;
  logic             ycbl_q, ycbl_d;
  logic             ynblhs_q, ynblhs_d;

  assign evt = a ^ a_prev_q;

  // Shift histories and compute transport, inertial and queued outputs
  always_comb begin
    hist_d    = hist_q;
    flag_d    = flag_q;
    hist_d[0] = a;
    flag_d[0] = evt;
    for (int i = 1; i < DELAY; i++) begin
      hist_d[i] = hist_q[i-1];
      flag_d[i] = flag_q[i-1];
    end

    ynbrhs_d = hist_q[DELAY-1];

    // Inertial: only a window of DELAY identical samples moves the output
    ycbl_d = ycbl_q;
    if (&hist_q) begin
      ycbl_d = 1'b1;
    end else if (~|hist_q) begin
      ycbl_d = 1'b0;
    end

    // Queued: an event from DELAY edges ago resamples the current input
    ynblhs_d = flag_q[DELAY-1] ? a : ynblhs_q;
  end

  // Registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      a_prev_q <= 1'b0;
      hist_q   <= '0;
      flag_q   <= '0;
      ynbrhs_q <= 1'b0;
      ycbl_q   <= 1'b0;
      ynblhs_q <= 1'b0;
    end else begin
      a_prev_q <= a;
      hist_q   <= hist_d;
      flag_q   <= flag_d;
      ynbrhs_q <= ynbrhs_d;
      ycbl_q   <= ycbl_d;
      ynblhs_q <= ynblhs_d;
    end
  end

  sdelay_blind_tracker #(
    .DELAY           (DELAY),
    .SAMPLE_AT_EVENT (1'b0)
  ) u_trk_lhs (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .evt (evt),
    .y   (yblhs)
  );

  sdelay_blind_tracker #(
    .DELAY           (DELAY),
    .SAMPLE_AT_EVENT (1'b1)
  ) u_trk_rhs (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .evt (evt),
    .y   (ybrhs)
  );

  assign ynbrhs = ynbrhs_q;
  assign ycbl   = ycbl_q;
  assign ynblhs = ynblhs_q;

endmodule

// File: tb/tb_sdelay.sv
// Purpose: directed bench for sdelay with DELAY=2, expected values written by hand.
// Latency: each step drives one edge and checks outputs 1 time unit later.
// Backpressure: none.
module tb_sdelay;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a   = 1'b1;
  logic yblhs, ybrhs, ynblhs, ynbrhs, ycbl;

  int checks = 0;
  int errors = 0;

  sdelay #(.DELAY(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .yblhs  (yblhs),
    .ybrhs  (ybrhs),
    .ynblhs (ynblhs),
    .ynbrhs (ynbrhs),
    .ycbl   (ycbl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string name, input logic obs, input logic expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s.%s: observed %b expected %b", tag, name, obs, expv);
    end
  endtask

  // exp = {yblhs, ybrhs, ynblhs, ynbrhs, ycbl} after the edge that samples av/rv
  task automatic step(input logic av, input logic rv, input logic [4:0] exp, input string tag);
    a   = av;
    rst = rv;
    @(posedge clk);
    #1;
    chk(tag, "yblhs",  yblhs,  exp[4]);
    chk(tag, "ybrhs",  ybrhs,  exp[3]);
    chk(tag, "ynblhs", ynblhs, exp[2]);
    chk(tag, "ynbrhs", ynbrhs, exp[1]);
    chk(tag, "ycbl",   ycbl,   exp[0]);
  endtask

  initial begin
    // Reset held two edges with a=1
    step(1'b1, 1'b1, 5'b00000, "rst0");
    step(1'b1, 1'b1, 5'b00000, "rst1");

    // Release with a=1: first edge is an event; rising step
    step(1'b1, 1'b0, 5'b00000, "up0");
    step(1'b1, 1'b0, 5'b00000, "up1");
    step(1'b1, 1'b0, 5'b11111, "up2");
    step(1'b1, 1'b0, 5'b11111, "up3");

    // Falling step
    step(1'b0, 1'b0, 5'b11111, "dn0");
    step(1'b0, 1'b0, 5'b11111, "dn1");
    step(1'b0, 1'b0, 5'b00000, "dn2");
    step(1'b0, 1'b0, 5'b00000, "dn3");

    // 1-cycle pulse: only transport and ybrhs see it; ybrhs latches 1
    step(1'b1, 1'b0, 5'b00000, "p1_0");
    step(1'b0, 1'b0, 5'b00000, "p1_1");
    step(1'b0, 1'b0, 5'b01010, "p1_2");
    for (int i = 3; i <= 10; i++) begin
      step(1'b0, 1'b0, 5'b01000, $sformatf("p1_%0d", i));
    end

    // 3-cycle pulse: all models pass it
    step(1'b1, 1'b0, 5'b01000, "p3_0");
    step(1'b1, 1'b0, 5'b01000, "p3_1");
    step(1'b1, 1'b0, 5'b11111, "p3_2");
    step(1'b0, 1'b0, 5'b11111, "p3_3");
    step(1'b0, 1'b0, 5'b11111, "p3_4");
    step(1'b0, 1'b0, 5'b00000, "p3_5");
    step(1'b0, 1'b0, 5'b00000, "p3_6");

    // Alternating 1,0,1,0 then 0
    step(1'b1, 1'b0, 5'b00000, "alt0");
    step(1'b0, 1'b0, 5'b00000, "alt1");
    step(1'b1, 1'b0, 5'b11110, "alt2");
    step(1'b0, 1'b0, 5'b11000, "alt3");
    step(1'b0, 1'b0, 5'b11010, "alt4");
    step(1'b0, 1'b0, 5'b00000, "alt5");
    step(1'b0, 1'b0, 5'b00000, "alt6");

    // Reset in the middle of WAIT drops the pending update
    step(1'b1, 1'b0, 5'b00000, "rw0");
    step(1'b1, 1'b1, 5'b00000, "rw1");
    step(1'b1, 1'b0, 5'b00000, "rw2");
    step(1'b1, 1'b0, 5'b00000, "rw3");
    step(1'b1, 1'b0, 5'b11111, "rw4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
